inst_fetch: RTL and testbench

//   Instruction-fetch initiator for the instruction ROM port: owns the PC and drives ROM chip-enable/address.
//   The ROM returns the instruction combinationally in the same cycle.

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_buf.sv | 69 ++++++
 rtl/inst_fetch.sv | 73 +++++++
 tb/tb_inst_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants, the buffered {pc,inst} entry type and the
// word-alignment helper used for redirect targets.
package inst_fetch_pkg;

    localparam int          INST_ADDR_W      = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic        CHIP_ENABLE      = 1'b1;
    localparam logic        CHIP_DISABLE     = 1'b0;
    localparam int          FETCH_BUF_DEPTH  = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Fetches are always word aligned, so redirect targets drop their low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// fetch_buf: synchronous FIFO of {pc,inst} entries. The head entry is kept in
// a register so the consumer sees it straight from a flop; clr beats push/pop.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic            do_push;
    logic            do_pop;
    fetch_entry_t    head_nxt;

    always_comb begin
        do_pop     = pop && (count != '0);
        do_push    = push && ((count != FULL) || do_pop);
        rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // The new head is the entry written this cycle only when nothing older remains.
        if (count_nxt == '0)
            head_nxt = '0;
        else if (do_push && (wr_ptr == rd_ptr_nxt))
            head_nxt = din;
        else
            head_nxt = mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, drives the ROM port and buffers fetched {pc,inst}
// pairs for decode; flush beats branch, and both drop everything buffered.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_BUF_DEPTH,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_tgt_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          redirect;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    // Handshake: an entry moves to decode on a cycle where if_valid and id_ready
    // are both high; if_valid never depends on id_ready, and a redirect cycle moves nothing.
    assign redirect = flush_i | branch_flag_i;
    assign pop      = if_valid & id_ready & ~redirect;
    assign push     = rom_ce & ((count != FULL) | pop) & ~redirect;
    assign wr_entry = '{pc: pc, inst: rom_inst};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rom_ce <= CHIP_DISABLE;
        end else begin
            rom_ce <= CHIP_ENABLE;
            if (flush_i)
                pc <= align_word(new_pc_i);
            else if (branch_flag_i)
                pc <= align_word(branch_tgt_i);
            else if (push)
                pc <= pc + 32'd4;
        end
    end

    fetch_buf #(.DEPTH(DEPTH)) u_fetch_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .count (count)
    );

    assign rom_addr = pc;
    assign if_valid = (count != '0);
    assign if_pc    = head.pc;
    assign if_inst  = head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomized checks of inst_fetch against a queue-based model of
// the fetch stream, plus explicit checks on the documented corner cases.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag_i;
    logic [31:0] branch_tgt_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_q[$];
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    assign rom_inst = rom_model(rom_addr);

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .branch_flag_i (branch_flag_i),
        .branch_tgt_i  (branch_tgt_i),
        .flush_i       (flush_i),
        .new_pc_i      (new_pc_i),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 64'h0;
        chk("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
        chk("rom_addr", rom_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, model_q.size() != 0});
        chk("if_pc", if_pc, head[63:32]);
        chk("if_inst", if_inst, head[31:0]);
    endtask

    // One clock: advance the model from the current inputs, clock, then compare.
    task automatic tick();
        logic m_pop;
        logic m_push;
        logic redirect;
        redirect = flush_i | branch_flag_i;
        if (!rst && !redirect && if_valid && id_ready)
            got_q.push_back(if_pc);
        if (rst) begin
            model_q.delete();
            m_pc = RESET_PC;
            m_ce = 1'b0;
        end else begin
            m_pop  = !redirect && (model_q.size() != 0) && id_ready;
            m_push = !redirect && m_ce && ((model_q.size() < DEPTH) || m_pop);
            if (m_pop)
                void'(model_q.pop_front());
            if (m_push)
                model_q.push_back({m_pc, rom_model(m_pc)});
            if (flush_i) begin
                model_q.delete();
                m_pc = {new_pc_i[31:2], 2'b00};
            end else if (branch_flag_i) begin
                model_q.delete();
                m_pc = {branch_tgt_i[31:2], 2'b00};
            end else if (m_push) begin
                m_pc = m_pc + 32'd4;
            end
            m_ce = 1'b1;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_delivered(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk(tag, got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst           = 1'b1;
        branch_flag_i = 1'b0;
        branch_tgt_i  = 32'h0;
        flush_i       = 1'b0;
        new_pc_i      = 32'h0;
        id_ready      = 1'b0;
        m_pc          = RESET_PC;
        m_ce          = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_inst", if_inst, ZERO_WORD);
        chk("rst_rom_ce", {31'b0, rom_ce}, 32'd0);
        chk("rst_rom_addr", rom_addr, RESET_PC);

        // Start-up latency and steady stream
        rst      = 1'b0;
        id_ready = 1'b1;
        tick();
        chk("first_ce", {31'b0, rom_ce}, 32'd1);
        chk("first_not_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("first_valid", {31'b0, if_valid}, 32'd1);
        chk("first_pc", if_pc, 32'h0000_0000);
        chk("first_inst", if_inst, 32'hA5A5_0000);
        tick();
        chk("second_pc", if_pc, 32'h0000_0004);
        repeat (3) tick();

        // Backpressure: fill, freeze, then release with no loss or duplicate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("bp_head_before", if_pc, 32'h0000_0008);
        id_ready = 1'b0;
        repeat (4) tick();
        chk("bp_rom_addr_frozen", rom_addr, 32'h0000_0010);
        chk("bp_head_held", if_pc, 32'h0000_0008);
        got_q.delete();
        exp_q = '{32'h8, 32'hC, 32'h10};
        id_ready = 1'b1;
        repeat (3) tick();
        check_delivered("bp_release");

        // Branch while full, unaligned target
        id_ready      = 1'b0;
        branch_flag_i = 1'b1;
        branch_tgt_i  = 32'h0000_0103;
        tick();
        branch_flag_i = 1'b0;
        chk("br_dropped", {31'b0, if_valid}, 32'd0);
        chk("br_rom_addr", rom_addr, 32'h0000_0100);
        tick();
        chk("br_valid", {31'b0, if_valid}, 32'd1);
        chk("br_pc", if_pc, 32'h0000_0100);

        // Flush beats branch
        flush_i       = 1'b1;
        new_pc_i      = 32'h0000_0180;
        branch_flag_i = 1'b1;
        branch_tgt_i  = 32'h0000_0200;
        tick();
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        chk("fl_rom_addr", rom_addr, 32'h0000_0180);
        tick();
        chk("fl_pc", if_pc, 32'h0000_0180);
        chk("fl_inst", if_inst, 32'hA5A5_0180);

        // PC wrap at the top of the address space
        id_ready = 1'b1;
        flush_i  = 1'b1;
        new_pc_i = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        tick();
        chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", if_pc, 32'h0000_0000);
        chk("wrap_inst2", if_inst, 32'hA5A5_0000);

        // Mid-operation reset with two entries buffered
        id_ready = 1'b0;
        repeat (2) tick();
        chk("mid_full_valid", {31'b0, if_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
        chk("mid_rst_ce", {31'b0, rom_ce}, 32'd0);
        chk("mid_rst_addr", rom_addr, RESET_PC);
        tick();
        chk("mid_restart_ce", {31'b0, rom_ce}, 32'd1);
        tick();
        chk("mid_restart_pc", if_pc, RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            flush_i       = ($urandom_range(0, 31) == 0);
            branch_flag_i = ($urandom_range(0, 15) == 0);
            branch_tgt_i  = $urandom;
            new_pc_i      = $urandom;
            id_ready      = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
